// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_serializer_pkg
// Shared definitions for the PISO serializer and its matching deserializer:
//   - default word / bit-counter widths
//   - FSM state encodings (ST_IDLE=0, ST_SHIFT=1, ST_PARITY=2)
//   - even-parity helper used when the PARITY_EN build option is enabled
// -----------------------------------------------------------------------------
package piso_serializer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Even parity (XOR reduction) of a zero-extended word.
    function automatic logic even_parity32(input logic [31:0] i_word);
        return ^i_word;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_serializer_bit_counter
// Position counter for the bit currently on the serial line.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (counter -> 0)
//   i_clr : synchronous clear (priority over i_en)
//   i_en  : advance by one
//   o_tc  : terminal count, high while the count equals TERM
// -----------------------------------------------------------------------------
module piso_serializer_bit_counter #(
    parameter int CNT_W = 5,
    parameter int TERM  = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TERM);

    logic [CNT_W-1:0] r_cnt;

    // Count register: reset/clear to zero, otherwise advance when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tc = (r_cnt == TERM_CNT);

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out shift register. A WIDTH-bit word is accepted over a
// valid/ready handshake and shifted out MSB-first, one bit per clock, with a
// qualifying strobe per bit and a done pulse on the final bit of each word.
// Build option: define PARITY_EN to append one even-parity bit per word
// (done/load_ready then move to that parity cycle).
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   load_valid : source presents a word on load_data
//   load_data  : parallel word to serialize
//   load_ready : block can accept a word this cycle
//   ser_out    : serial data bit
//   ser_valid  : ser_out carries a valid bit
//   busy       : a word is in flight
//   done       : one-cycle pulse on the final serial bit of a word
// -----------------------------------------------------------------------------
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic             w_tc;
    logic             w_accept;
    logic             w_load_ready;
    logic             w_ser_bit;
    logic             w_ser_valid;
    logic             w_done;
    logic             w_cnt_clr;
    logic             w_cnt_en;
`ifdef PARITY_EN
    logic             r_parity;
`endif

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        w_ser_valid  = 1'b0;
        w_ser_bit    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_ready = 1'b1;
                if (load_valid) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_ser_valid = 1'b1;
                w_ser_bit   = r_shift[WIDTH-1];
                if (w_tc) begin
`ifdef PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    // Last data bit doubles as the load slot: no idle gap.
                    w_done       = 1'b1;
                    w_load_ready = 1'b1;
                    if (load_valid) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`endif
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                w_ser_valid  = 1'b1;
                w_ser_bit    = r_parity;
                w_done       = 1'b1;
                w_load_ready = 1'b1;
                if (load_valid) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = load_valid & w_load_ready;

    // Counter restarts on every capture and whenever we are not mid-word.
    assign w_cnt_en  = (r_state == ST_SHIFT);
    assign w_cnt_clr = w_accept | (r_state != ST_SHIFT) | w_tc;

    piso_serializer_bit_counter #(
        .CNT_W (CNT_W),
        .TERM  (WIDTH - 1)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register: capture on accept, shift left with zero fill while shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= load_data;
        end else if (r_state == ST_SHIFT) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        end else begin
            r_shift <= r_shift;
        end
    end

`ifdef PARITY_EN
    // Parity of the word is taken at capture, before shifting destroys it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= even_parity32(32'(load_data));
        end else begin
            r_parity <= r_parity;
        end
    end
`endif

    assign load_ready = w_load_ready;
    assign ser_out    = w_ser_bit;
    assign ser_valid  = w_ser_valid;
    assign busy       = w_ser_valid;
    assign done       = w_done;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Scoreboard bench: every word the model expects to be accepted expands into
// its serial bit stream (plus done markers) in a queue; a negedge monitor pops
// one entry per ser_valid cycle and also checks handshake/idle outputs.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 5;
`ifdef PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    typedef struct packed {
        logic b;
        logic d;
    } item_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    item_t exp_q[$];
    int    rem     = 0;
    bit    mon_en  = 1'b0;
    int    total   = 0;
    int    bad     = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expand one accepted word into its expected serial stream.
    task automatic push_word(input logic [WIDTH-1:0] w);
        item_t it;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            it.b = w[i];
`ifdef PARITY_EN
            it.d = 1'b0;
`else
            it.d = (i == 0);
`endif
            exp_q.push_back(it);
        end
`ifdef PARITY_EN
        it.b = ^w;
        it.d = 1'b1;
        exp_q.push_back(it);
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic cycle(input logic r, input logic lv, input logic [WIDTH-1:0] d);
        bit ready_exp;
        rst        = r;
        load_valid = lv;
        load_data  = d;
        ready_exp  = (rem <= 1);
        @(posedge clk);
        #1;
        if (r) begin
            rem = 0;
            exp_q.delete();
        end else begin
            if (rem > 0) rem--;
            if (lv && ready_exp) begin
                push_word(d);
                rem = NBITS;
            end
        end
    endtask

    // Monitor: compare outputs mid-cycle against the model.
    always @(negedge clk) begin
        item_t it;
        if (mon_en) begin
            chk("ser_valid", 32'(ser_valid), 32'(rem != 0));
            chk("busy", 32'(busy), 32'(rem != 0));
            chk("load_ready", 32'(load_ready), 32'(rem <= 1));
            if (ser_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    it = exp_q.pop_front();
                    chk("ser_out", 32'(ser_out), 32'(it.b));
                    chk("done", 32'(done), 32'(it.d));
                end
            end else begin
                chk("idle_ser_out", 32'(ser_out), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        // Reset held for two cycles.
        cycle(1'b1, 1'b1, 8'hFF);
        mon_en = 1'b1;
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ser_out", 32'(ser_out), 32'd0);

        // Single word, then idle.
        cycle(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < NBITS + 2; i++) cycle(1'b0, 1'b0, 8'h00);

        // Back-to-back: 3C offered on the last cycle of A5.
        cycle(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < NBITS - 1; i++) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < NBITS + 2; i++) cycle(1'b0, 1'b0, 8'h00);

        // Ignored load during the 3rd bit of 81.
        cycle(1'b0, 1'b1, 8'h81);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < NBITS + 2; i++) cycle(1'b0, 1'b0, 8'h00);

        // Reset during the 4th bit of F0, then 0F.
        cycle(1'b0, 1'b1, 8'hF0);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'hAA);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(load_ready), 32'd1);
        cycle(1'b0, 1'b1, 8'h0F);
        for (int i = 0; i < NBITS + 2; i++) cycle(1'b0, 1'b0, 8'h00);

        // Parity corner words (plain data in the default build).
        cycle(1'b0, 1'b1, 8'h07);
        for (int i = 0; i < NBITS - 1; i++) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h03);
        for (int i = 0; i < NBITS + 2; i++) cycle(1'b0, 1'b0, 8'h00);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  WIDTH'($urandom));
        end

        for (int i = 0; i < NBITS + 3; i++) cycle(1'b0, 1'b0, 8'h00);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
